// File: rtl/breakout_pkg.sv
// Shared Breakout geometry defaults and the ball state encoding.
// Used by the paddle, ball and renderer stages.
package breakout_pkg;

  localparam int unsigned SCREEN_W_DEF    = 640;
  localparam int unsigned SCREEN_H_DEF    = 480;
  localparam int unsigned BALL_SIZE_DEF   = 4;
  localparam int unsigned PADDLE_HALF_DEF = 40;
  localparam int unsigned PADDLE_Y_DEF    = 460;

  typedef enum logic [1:0] {
    StServe    = 2'd0,
    StMove     = 2'd1,
    StGameOver = 2'd2
  } ball_state_e;

  // Zero-extend a screen coordinate so that +size sums cannot wrap.
  function automatic logic [10:0] widen(input logic [9:0] v);
    return {1'b0, v};
  endfunction

endpackage

// File: rtl/ball_collide.sv
// Combinational collision and motion step for one frame of ball movement.
// Direction bits: 1 means +1 along that axis, 0 means -1.
module ball_collide
  import breakout_pkg::*;
#(
  parameter int unsigned SCREEN_W    = SCREEN_W_DEF,
  parameter int unsigned SCREEN_H    = SCREEN_H_DEF,
  parameter int unsigned BALL_SIZE   = BALL_SIZE_DEF,
  parameter int unsigned PADDLE_HALF = PADDLE_HALF_DEF,
  parameter int unsigned PADDLE_Y    = PADDLE_Y_DEF
) (
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       dx_pos,
  input  logic       dy_pos,
  input  logic [9:0] paddle_x,
  output logic [9:0] next_x,
  output logic [9:0] next_y,
  output logic       next_dx_pos,
  output logic       next_dy_pos,
  output logic       wall_hit,
  output logic       paddle_hit,
  output logic       bottom_hit
);

  localparam logic [10:0] W    = 11'(SCREEN_W);
  localparam logic [10:0] H    = 11'(SCREEN_H);
  localparam logic [10:0] BS   = 11'(BALL_SIZE);
  localparam logic [10:0] HB   = 11'(BALL_SIZE / 2);
  localparam logic [10:0] PH   = 11'(PADDLE_HALF);
  localparam logic [10:0] PY   = 11'(PADDLE_Y);

  logic [10:0] x_w, y_w, px_w;
  logic        left, right, top, pad;

  assign x_w  = widen(x);
  assign y_w  = widen(y);
  assign px_w = widen(paddle_x);

  assign left       = !dx_pos && (x == 10'd0);
  assign right      = dx_pos && (x_w + BS == W);
  assign top        = !dy_pos && (y == 10'd0);
  assign pad        = dy_pos && (y_w + BS == PY) &&
                      (x_w + BS > px_w - PH) && (x_w < px_w + PH);
  assign bottom_hit = dy_pos && (y_w + BS == H);

  // A wall reflection decides dx over the paddle's side-based steering.
  always_comb begin
    next_dx_pos = dx_pos;
    if (left) begin
      next_dx_pos = 1'b1;
    end else if (right) begin
      next_dx_pos = 1'b0;
    end else if (pad) begin
      next_dx_pos = !(x_w + HB < px_w);
    end
  end

  assign next_dy_pos = top ? 1'b1 : (pad ? 1'b0 : dy_pos);

  assign next_x = (left || right) ? x : (next_dx_pos ? x + 10'd1 : x - 10'd1);
  assign next_y = (top || pad) ? y : (dy_pos ? y + 10'd1 : y - 10'd1);

  // Losing the ball suppresses every other event on that frame.
  assign wall_hit   = (left || right || top) && !bottom_hit;
  assign paddle_hit = pad && !bottom_hit;

endmodule

// File: rtl/ball_motion.sv
// Breakout ball engine: serve/move/game-over FSM, ball registers and lives.
// Motion advances once per frame_tick; all outputs come straight from registers.
module ball_motion
  import breakout_pkg::*;
#(
  parameter int unsigned SCREEN_W    = SCREEN_W_DEF,
  parameter int unsigned SCREEN_H    = SCREEN_H_DEF,
  parameter int unsigned BALL_SIZE   = BALL_SIZE_DEF,
  parameter int unsigned PADDLE_HALF = PADDLE_HALF_DEF,
  parameter int unsigned PADDLE_Y    = PADDLE_Y_DEF,
  parameter int unsigned LIVES_INIT  = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       launch,
  input  logic [9:0] paddle_x,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       ball_active,
  output logic       wall_hit,
  output logic       paddle_hit,
  output logic       ball_lost,
  output logic [1:0] lives,
  output logic       game_over
);

  localparam logic [9:0] HALF_BALL = 10'(BALL_SIZE / 2);
  localparam logic [9:0] START_X   = 10'(SCREEN_W / 2 - BALL_SIZE / 2);
  localparam logic [9:0] SERVE_Y   = 10'(PADDLE_Y - BALL_SIZE);

  ball_state_e state_q, state_d;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic        dx_pos_q, dx_pos_d, dy_pos_q, dy_pos_d;
  logic [1:0]  lives_q, lives_d;
  logic        wall_q, wall_d, pad_q, pad_d, lost_q, lost_d;

  logic [9:0]  col_x, col_y;
  logic        col_dx_pos, col_dy_pos, col_wall, col_pad, col_bottom;

  ball_collide #(
    .SCREEN_W   (SCREEN_W),
    .SCREEN_H   (SCREEN_H),
    .BALL_SIZE  (BALL_SIZE),
    .PADDLE_HALF(PADDLE_HALF),
    .PADDLE_Y   (PADDLE_Y)
  ) u_collide (
    .x          (x_q),
    .y          (y_q),
    .dx_pos     (dx_pos_q),
    .dy_pos     (dy_pos_q),
    .paddle_x   (paddle_x),
    .next_x     (col_x),
    .next_y     (col_y),
    .next_dx_pos(col_dx_pos),
    .next_dy_pos(col_dy_pos),
    .wall_hit   (col_wall),
    .paddle_hit (col_pad),
    .bottom_hit (col_bottom)
  );

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    dx_pos_d = dx_pos_q;
    dy_pos_d = dy_pos_q;
    lives_d  = lives_q;
    wall_d   = 1'b0;
    pad_d    = 1'b0;
    lost_d   = 1'b0;
    if (frame_tick) begin
      unique case (state_q)
        StServe: begin
          x_d = paddle_x - HALF_BALL;
          y_d = SERVE_Y;
          if (launch) begin
            state_d  = StMove;
            dx_pos_d = 1'b1;
            dy_pos_d = 1'b0;
          end
        end
        StMove: begin
          if (col_bottom) begin
            lost_d  = 1'b1;
            lives_d = lives_q - 2'd1;
            if (lives_q == 2'd1) begin
              // Last ball: freeze where it fell.
              state_d = StGameOver;
            end else begin
              state_d = StServe;
              x_d     = paddle_x - HALF_BALL;
              y_d     = SERVE_Y;
            end
          end else begin
            x_d      = col_x;
            y_d      = col_y;
            dx_pos_d = col_dx_pos;
            dy_pos_d = col_dy_pos;
            wall_d   = col_wall;
            pad_d    = col_pad;
          end
        end
        StGameOver: ;
        default: state_d = StServe;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StServe;
      x_q      <= START_X;
      y_q      <= SERVE_Y;
      dx_pos_q <= 1'b1;
      dy_pos_q <= 1'b0;
      lives_q  <= 2'(LIVES_INIT);
      wall_q   <= 1'b0;
      pad_q    <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      dx_pos_q <= dx_pos_d;
      dy_pos_q <= dy_pos_d;
      lives_q  <= lives_d;
      wall_q   <= wall_d;
      pad_q    <= pad_d;
      lost_q   <= lost_d;
    end
  end

  assign ball_x      = x_q;
  assign ball_y      = y_q;
  assign ball_active = (state_q == StMove);
  assign game_over   = (state_q == StGameOver);
  assign wall_hit    = wall_q;
  assign paddle_hit  = pad_q;
  assign ball_lost   = lost_q;
  assign lives       = lives_q;

endmodule

// File: tb/tb_ball_motion.sv
// Self-checking bench for ball_motion: directed scenarios plus random play
// compared against a frame-level behavioural model of the ball.
module tb_ball_motion;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       launch = 1'b0;
  logic [9:0] paddle_x = 10'd320;
  logic [9:0] ball_x, ball_y;
  logic       ball_active, wall_hit, paddle_hit, ball_lost, game_over;
  logic [1:0] lives;

  ball_motion dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .launch     (launch),
    .paddle_x   (paddle_x),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .ball_active(ball_active),
    .wall_hit   (wall_hit),
    .paddle_hit (paddle_hit),
    .ball_lost  (ball_lost),
    .lives      (lives),
    .game_over  (game_over)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: 0 serve, 1 move, 2 game over. Directions are +1 / -1.
  int m_state, m_x, m_y, m_dx, m_dy, m_lives;
  int m_wall, m_pad, m_lost;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".x"}, int'(ball_x), m_x);
    check({tag, ".y"}, int'(ball_y), m_y);
    check({tag, ".active"}, int'(ball_active), (m_state == 1) ? 1 : 0);
    check({tag, ".over"}, int'(game_over), (m_state == 2) ? 1 : 0);
    check({tag, ".lives"}, int'(lives), m_lives);
    check({tag, ".wall"}, int'(wall_hit), m_wall);
    check({tag, ".pad"}, int'(paddle_hit), m_pad);
    check({tag, ".lost"}, int'(ball_lost), m_lost);
  endtask

  task automatic model_reset();
    m_state = 0; m_x = 318; m_y = 456; m_dx = 1; m_dy = -1; m_lives = 3;
    m_wall = 0; m_pad = 0; m_lost = 0;
  endtask

  task automatic model_step(input bit l, input int px);
    bit left, right, top, pad;
    int ndx, ndy;
    m_wall = 0; m_pad = 0; m_lost = 0;
    if (m_state == 0) begin
      m_x = px - 2; m_y = 456;
      if (l) begin m_state = 1; m_dx = 1; m_dy = -1; end
    end else if (m_state == 1) begin
      if (m_dy == 1 && m_y + 4 == 480) begin
        m_lost = 1;
        m_lives--;
        if (m_lives == 0) m_state = 2;
        else begin m_state = 0; m_x = px - 2; m_y = 456; end
      end else begin
        left  = (m_dx == -1 && m_x == 0);
        right = (m_dx == 1 && m_x + 4 == 640);
        top   = (m_dy == -1 && m_y == 0);
        pad   = (m_dy == 1 && m_y + 4 == 460 && m_x + 4 > px - 40 && m_x < px + 40);
        ndx = m_dx;
        if (pad) ndx = (m_x + 2 < px) ? -1 : 1;
        if (left) ndx = 1;
        if (right) ndx = -1;
        ndy = m_dy;
        if (top) ndy = 1;
        if (pad) ndy = -1;
        if (!(left || right)) m_x += ndx;
        if (!(top || pad)) m_y += m_dy;
        m_dx = ndx; m_dy = ndy;
        m_wall = (left || right || top) ? 1 : 0;
        m_pad = pad ? 1 : 0;
      end
    end
  endtask

  task automatic do_reset(input bit with_tick);
    reset = 1'b1; frame_tick = with_tick; launch = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; frame_tick = 1'b0; launch = 1'b0;
    model_reset();
    compare_all("reset");
  endtask

  task automatic do_tick(input bit l, input int px, input int gap);
    paddle_x = 10'(px); launch = l; frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    model_step(l, px);
    compare_all("tick");
    if (gap > 0) begin
      paddle_x = 10'(41 + $urandom_range(558));
      launch = $urandom_range(1);
      repeat (gap) @(posedge clk);
      #1;
      m_wall = 0; m_pad = 0; m_lost = 0;
      compare_all("idle");
    end
  endtask

  function automatic int avoid_px();
    return (m_x < 320) ? 599 : 41;
  endfunction

  function automatic int clamp_px(input int v);
    if (v < 41) return 41;
    if (v > 599) return 599;
    return v;
  endfunction

  task automatic play_until_lost(input int limit);
    int n = 0;
    do begin
      do_tick(1'b0, avoid_px(), 0);
      n++;
    end while (!ball_lost && n < limit);
    check("lost_pulse", int'(ball_lost), 1);
  endtask

  initial begin
    int n;
    // Reset and idle.
    do_reset(1'b0);
    check("rst_x", int'(ball_x), 318);
    check("rst_y", int'(ball_y), 456);
    check("rst_lives", int'(lives), 3);
    repeat (3) @(posedge clk);
    #1 compare_all("rst_idle");

    // Serve follows paddle; launch tick does not move.
    do_tick(1'b0, 200, 1);
    check("serve_x", int'(ball_x), 198);
    do_tick(1'b1, 200, 0);
    check("launch_active", int'(ball_active), 1);
    check("launch_x", int'(ball_x), 198);
    do_tick(1'b0, 200, 0);
    check("first_move_x", int'(ball_x), 199);
    check("first_move_y", int'(ball_y), 455);

    // Right wall.
    do_reset(1'b0);
    do_tick(1'b0, 599, 0);
    do_tick(1'b1, 599, 0);
    for (int i = 0; i < 39; i++) do_tick(1'b0, 599, 0);
    check("right_x", int'(ball_x), 636);
    do_tick(1'b0, 599, 0);
    check("right_hold_x", int'(ball_x), 636);
    check("right_wall", int'(wall_hit), 1);
    do_tick(1'b0, 599, 0);
    check("right_back_x", int'(ball_x), 635);

    // Top wall then paddle catch.
    do_reset(1'b0);
    do_tick(1'b1, 320, 0);
    n = 0;
    while (ball_y != 10'd0 && n < 600) begin do_tick(1'b0, 320, 0); n++; end
    check("top_moves", n, 456);
    do_tick(1'b0, 320, 0);
    check("top_wall", int'(wall_hit), 1);
    check("top_hold_y", int'(ball_y), 0);
    n = 0;
    while (!paddle_hit && n < 600) begin do_tick(1'b0, clamp_px(m_x + 2), 0); n++; end
    check("pad_hit", int'(paddle_hit), 1);
    check("pad_y", int'(ball_y), 456);
    do_tick(1'b0, clamp_px(m_x + 2), 0);
    check("pad_up_y", int'(ball_y), 455);

    // Lose all three balls.
    play_until_lost(1200);
    check("lost1_lives", int'(lives), 2);
    check("lost1_y", int'(ball_y), 456);
    check("lost1_active", int'(ball_active), 0);
    do_tick(1'b1, 300, 0);
    play_until_lost(1200);
    do_tick(1'b1, 450, 0);
    play_until_lost(1200);
    check("over_lives", int'(lives), 0);
    check("over_flag", int'(game_over), 1);
    for (int i = 0; i < 4; i++) do_tick(1'b1, 41 + $urandom_range(558), 1);
    do_reset(1'b1);
    check("rearm_lives", int'(lives), 3);

    // Random play with a paddle that mostly tracks the ball.
    for (int g = 0; g < 3; g++) begin
      do_reset($urandom_range(1));
      for (int t = 0; t < 3000 && m_state != 2; t++) begin
        int px;
        if ($urandom_range(9) < 7)
          px = clamp_px(m_x + 2 + int'($urandom_range(90)) - 45);
        else
          px = 41 + int'($urandom_range(558));
        do_tick($urandom_range(3) == 0, px, int'($urandom_range(2)));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
